// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arbiter_pkg;

  // Arbiter port state: idle waiting for a request, or owning data_mem.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Requester identifiers, also the encoding of grant_id.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // data_mem access modes; instruction fetches always use the word mode.
  localparam logic [2:0] DATA_ADDR_MODE_BYTE  = 3'd0;
  localparam logic [2:0] DATA_ADDR_MODE_HALF  = 3'd1;
  localparam logic [2:0] DATA_ADDR_MODE_WORD  = 3'd2;
  localparam logic [2:0] DATA_ADDR_MODE_BYTEU = 3'd4;
  localparam logic [2:0] DATA_ADDR_MODE_HALFU = 3'd5;

  // The requester that gets priority after the given one is served.
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. A lone requester always wins;
// on a tie, prio selects the winner.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic grant_valid,
  output logic grant_id
);

  // Pick the winner for this cycle.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = REQ_I;
    if (req0 && req1) grant_id = prio;
    else if (req1)    grant_id = REQ_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data_mem port between instruction refill (read-only)
// and the data cache. One transaction at a time, each occupying the port
// for MEM_LATENCY cycles; the owner receives a one-cycle ack in the last one.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 4   // 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction side
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  // data side
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_addr_mode,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // data_mem
  output logic                  mem_we,
  output logic [2:0]            mem_addr_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // status
  output logic                  busy,
  output logic                  grant_id
);

  // Counter is reset on every entry to BUSY, so 4 bits cover latency 15.
  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  arb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  prio_q, prio_d;
  logic                  gid_q, gid_d;
  logic                  we_q, we_d;
  logic [2:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;

  logic arb_valid;
  logic arb_id;
  logic last;

  rr_arb2 u_rr_arb2 (
    .req0        (i_req),
    .req1        (d_req),
    .prio        (prio_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  assign last = (state_q == BUSY) && (cnt_q == CNT_LAST);

  // Next-state, latch capture and per-cycle outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    gid_d    = gid_q;
    we_d     = we_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;

    busy     = 1'b0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          gid_d   = arb_id;
          if (arb_id == REQ_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
            mode_d  = d_addr_mode;
          end else begin
            addr_d  = i_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            mode_d  = DATA_ADDR_MODE_WORD;
          end
        end
      end
      BUSY: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          // Single write edge and single ack, both in the final cycle.
          mem_we  = we_q;
          state_d = IDLE;
          prio_d  = other_req(gid_q);
          if (gid_q == REQ_D) begin
            d_ack    = 1'b1;
            drdata_d = mem_rdata;
          end else begin
            i_ack    = 1'b1;
            irdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is combinational from memory in the ack cycle, held otherwise.
  assign i_rdata       = i_ack ? mem_rdata : irdata_q;
  assign d_rdata       = d_ack ? mem_rdata : drdata_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_addr_mode = mode_q;
  assign grant_id      = gid_q;

  // State, counter, priority and transaction latches; reset drops any
  // in-flight transaction without acking it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prio_q   <= REQ_I;
      gid_q    <= REQ_I;
      we_q     <= 1'b0;
      mode_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      gid_q    <= gid_d;
      we_q     <= we_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

endmodule
